// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks the register writers in flight in EX, MEM and WB next to the ID
//   stage of the 5-stage LC-3b pipeline. It finds the hazards that operand
//   forwarding cannot cover (load-use, and WB-to-ID when the register file
//   has no write-through bypass), and drives the ID stall / EX bubble controls.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   pipe_advance        pipeline registers load this cycle
//   flush               taken branch/jump resolved in MEM; kill EX and MEM
//   id_valid, id_regwrite, id_is_load, id_destreg   ID instruction writer info
//   id_sr1/id_sr1_used, id_sr2/id_sr2_used           ID source operands
//   load_use_stall      hold PC and IF/ID
//   bubble_inject       ID/EX loads a NOP this cycle
//   pending_mask        bit r set while any in-flight stage will write r
//   stall_count         saturating count of injected bubbles
module hazard_scoreboard #(
   parameter int NUM_REGS  = 8,
   parameter int REG_W     = 3,
   parameter int WB_BYPASS = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pipe_advance,
   input  logic                flush,
   input  logic                id_valid,
   input  logic                id_regwrite,
   input  logic                id_is_load,
   input  logic [REG_W-1:0]    id_destreg,
   input  logic [REG_W-1:0]    id_sr1,
   input  logic                id_sr1_used,
   input  logic [REG_W-1:0]    id_sr2,
   input  logic                id_sr2_used,
   output logic                load_use_stall,
   output logic                bubble_inject,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic [15:0]         stall_count
);

   // Shadow entries: v is control (reset), rw/ld/dst are payload (no reset).
   logic             ex_v, mem_v, wb_v;
   logic             ex_rw, mem_rw, wb_rw;
   logic             ex_ld, mem_ld, wb_ld;
   logic [REG_W-1:0] ex_dst, mem_dst, wb_dst;
   logic             flush_pending;
   logic             flush_eff;
   logic             hit_ex, hit_wb;
   logic             id_enters_ex;

   function automatic logic src_hit(input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] s1, input logic u1,
                                    input logic [REG_W-1:0] s2, input logic u2);
      return (u1 && (s1 == dst)) || (u2 && (s2 == dst));
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
      return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction

   // A flush seen while the pipe was frozen still kills at the next advance.
   assign flush_eff = flush || flush_pending;

   assign hit_ex = ex_v && ex_rw && ex_ld &&
                   src_hit(ex_dst, id_sr1, id_sr1_used, id_sr2, id_sr2_used);

   // Without a register-file write-through, a WB writer is invisible to ID.
   assign hit_wb = (WB_BYPASS == 0) && wb_v && wb_rw &&
                   src_hit(wb_dst, id_sr1, id_sr1_used, id_sr2, id_sr2_used);

   assign load_use_stall = id_valid && !flush_eff && (hit_ex || hit_wb);
   assign bubble_inject  = load_use_stall && pipe_advance;
   assign id_enters_ex   = id_valid && !load_use_stall;

   always_comb begin
      pending_mask = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         if ((ex_v  && ex_rw  && (ex_dst  == REG_W'(r))) ||
             (mem_v && mem_rw && (mem_dst == REG_W'(r))) ||
             (wb_v  && wb_rw  && (wb_dst  == REG_W'(r))))
            pending_mask[r] = 1'b1;
      end
   end

   // ---- stage boundary: ID -> EX -> MEM -> WB (valid bits, flush, counter)
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_v          <= 1'b0;
         mem_v         <= 1'b0;
         wb_v          <= 1'b0;
         flush_pending <= 1'b0;
         stall_count   <= '0;
      end else begin
         if (pipe_advance) begin
            wb_v <= mem_v;
            if (flush_eff) begin
               mem_v <= 1'b0;
               ex_v  <= 1'b0;
            end else begin
               mem_v <= ex_v;
               ex_v  <= id_enters_ex;
            end
            flush_pending <= 1'b0;
         end else if (flush) begin
            flush_pending <= 1'b1;
         end
         if (bubble_inject)
            stall_count <= sat_inc(stall_count);
      end
   end

   // ---- stage boundary: ID -> EX -> MEM -> WB (payload; qualified by v)
   always_ff @(posedge clk) begin
      if (pipe_advance) begin
         wb_rw  <= mem_rw;
         wb_ld  <= mem_ld;
         wb_dst <= mem_dst;
         if (!flush_eff) begin
            mem_rw  <= ex_rw;
            mem_ld  <= ex_ld;
            mem_dst <= ex_dst;
            ex_rw   <= id_enters_ex && id_regwrite;
            ex_ld   <= id_enters_ex && id_is_load;
            ex_dst  <= id_destreg;
         end
      end
   end

endmodule
